keypad_guess_entry: RTL

- Upstream stage of the UART transmit path. Scans a 4x4 matrix keypad and debounces it.
- Composes an uppercase ASCII letter by phone-style multi-tap and presents it as msg with a one-cycle ready strobe when the player confirms.
- Its outputs feed the transmitter's msg and ready inputs directly. The host's guess therefore reaches game logic via TX -> RX -> buffer.

---
 rtl/keypad_guess_entry.sv | 211 +++++++++++++++++++++
 1 files changed

// File: rtl/keypad_guess_entry.sv
// Scans and debounces a 4x4 keypad, composes an uppercase letter by multi-tap
// and emits it with a one-cycle ready strobe on '#' for the UART transmitter.
module keypad_guess_entry #(
  parameter int SCAN_DIV   = 100,
  parameter int DEB_FRAMES = 4
) (
  input  logic       clk,
  input  logic       nRst,
  input  logic [3:0] row,
  input  logic       tx_busy,
  output logic [3:0] col,
  output logic [7:0] msg,
  output logic       ready,
  output logic       composing
);

  localparam int DW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int CW = $clog2(DEB_FRAMES + 1);
  localparam logic [DW-1:0] DIV_LAST = DW'(SCAN_DIV - 1);
  localparam logic [CW-1:0] DEB_LAST = CW'(DEB_FRAMES);

  // Key codes are {row, col}.
  localparam logic [3:0] KEY_STAR = 4'hC;
  localparam logic [3:0] KEY_HASH = 4'hE;

  typedef enum logic {S_RELEASED, S_PRESSED} deb_state_e;

  logic [3:0]    row_s1_q, row_s2_q;
  logic [DW-1:0] div_q, div_d;
  logic [1:0]    col_idx_q, col_idx_d;
  logic [1:0]    hits_q, hits_d;
  logic [3:0]    acc_key_q, acc_key_d;
  deb_state_e    state_q, state_d;
  logic [3:0]    cand_q, cand_d;
  logic [CW-1:0] deb_cnt_q, deb_cnt_d;
  logic [3:0]    cur_key_q, cur_key_d;
  logic [1:0]    tap_q, tap_d;
  logic [7:0]    msg_q, msg_d;
  logic          composing_q, composing_d;
  logic          pending_q, pending_d;
  logic          ready_q, ready_d;

  logic          sample, frame_end, frame_hit, press;
  logic [2:0]    pop, tot;
  logic [1:0]    row_idx, tap_next;
  logic [CW-1:0] cnt_inc, cnt_new;
  logic [7:0]    base;
  logic          is_digit;

  // Scan timing and per-frame contact accumulation.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no latch is inferred.
    sample    = (div_q == DIV_LAST);
    frame_end = sample && (col_idx_q == 2'd3);
    div_d     = sample ? '0 : div_q + 1'b1;
    col_idx_d = sample ? col_idx_q + 2'd1 : col_idx_q;

    pop = 3'(row_s2_q[0]) + 3'(row_s2_q[1]) + 3'(row_s2_q[2]) + 3'(row_s2_q[3]);
    row_idx = 2'd0;
    for (int r = 0; r < 4; r++) begin
      if (row_s2_q[r]) row_idx = 2'(r);
    end
    tot       = {1'b0, hits_q} + pop;
    hits_d    = hits_q;
    acc_key_d = acc_key_q;
    if (sample) begin
      hits_d = (tot >= 3'd2) ? 2'd2 : tot[1:0];
      if (pop == 3'd1) acc_key_d = {row_idx, col_idx_q};
    end
    frame_hit = (tot == 3'd1);
    if (frame_end) hits_d = 2'd0;
  end

  // Debounce: a key must persist DEB_FRAMES frames to press, NONE as long to release.
  always_comb begin
    state_d   = state_q;
    cand_d    = cand_q;
    deb_cnt_d = deb_cnt_q;
    press     = 1'b0;
    cnt_inc   = deb_cnt_q + 1'b1;
    cnt_new   = (acc_key_d == cand_q) ? cnt_inc : CW'(1);
    if (frame_end) begin
      case (state_q)
        S_RELEASED: begin
          if (frame_hit) begin
            cand_d = acc_key_d;
            if (cnt_new == DEB_LAST) begin
              press     = 1'b1;
              state_d   = S_PRESSED;
              deb_cnt_d = '0;
            end else begin
              deb_cnt_d = cnt_new;
            end
          end else begin
            deb_cnt_d = '0;
          end
        end
        default: begin
          if (frame_hit) begin
            deb_cnt_d = '0;
          end else if (cnt_inc == DEB_LAST) begin
            state_d   = S_RELEASED;
            deb_cnt_d = '0;
          end else begin
            deb_cnt_d = cnt_inc;
          end
        end
      endcase
    end
  end

  // Multi-tap compose and commit handshake.
  always_comb begin
    cur_key_d   = cur_key_q;
    tap_d       = tap_q;
    msg_d       = msg_q;
    composing_d = composing_q;
    pending_d   = pending_q;
    ready_d     = 1'b0;

    is_digit = (acc_key_d[3:2] != 2'd3) && (acc_key_d[1:0] != 2'd3) && (acc_key_d != 4'h0);
    case (acc_key_d)
      4'h1:    base = 8'h41;
      4'h2:    base = 8'h44;
      4'h4:    base = 8'h47;
      4'h5:    base = 8'h4A;
      4'h6:    base = 8'h4D;
      4'h8:    base = 8'h50;
      4'h9:    base = 8'h54;
      default: base = 8'h57;
    endcase
    tap_next = 2'd0;
    if (composing_q && acc_key_d == cur_key_q) begin
      if ((acc_key_d == 4'h8 || acc_key_d == 4'hA) ? (tap_q == 2'd3) : (tap_q == 2'd2))
        tap_next = 2'd0;
      else
        tap_next = tap_q + 2'd1;
    end

    if (ready_q) begin
      msg_d       = 8'h00;
      composing_d = 1'b0;
    end else begin
      if (pending_q && !tx_busy) begin
        ready_d   = 1'b1;
        pending_d = 1'b0;
      end
      if (press) begin
        if (acc_key_d == KEY_STAR) begin
          msg_d       = 8'h00;
          composing_d = 1'b0;
          pending_d   = 1'b0;
          ready_d     = 1'b0;
        end else if (!pending_q) begin
          if (is_digit) begin
            cur_key_d   = acc_key_d;
            tap_d       = tap_next;
            msg_d       = base + {6'd0, tap_next};
            composing_d = 1'b1;
          end else if (acc_key_d == KEY_HASH && composing_q) begin
            if (tx_busy) pending_d = 1'b1;
            else         ready_d   = 1'b1;
          end
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    // NOTE: reset is sampled on the clock edge; all state uses non-blocking assignments.
    if (!nRst) begin
      row_s1_q    <= '0;
      row_s2_q    <= '0;
      div_q       <= '0;
      col_idx_q   <= '0;
      hits_q      <= '0;
      acc_key_q   <= '0;
      state_q     <= S_RELEASED;
      cand_q      <= '0;
      deb_cnt_q   <= '0;
      cur_key_q   <= '0;
      tap_q       <= '0;
      msg_q       <= 8'h00;
      composing_q <= 1'b0;
      pending_q   <= 1'b0;
      ready_q     <= 1'b0;
    end else begin
      row_s1_q    <= row;
      row_s2_q    <= row_s1_q;
      div_q       <= div_d;
      col_idx_q   <= col_idx_d;
      hits_q      <= hits_d;
      acc_key_q   <= acc_key_d;
      state_q     <= state_d;
      cand_q      <= cand_d;
      deb_cnt_q   <= deb_cnt_d;
      cur_key_q   <= cur_key_d;
      tap_q       <= tap_d;
      msg_q       <= msg_d;
      composing_q <= composing_d;
      pending_q   <= pending_d;
      ready_q     <= ready_d;
    end
  end

  assign col       = 4'b0001 << col_idx_q;
  assign msg       = msg_q;
  assign ready     = ready_q;
  assign composing = composing_q;

endmodule
